// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             abort;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, src1, src2, abort,
    input  result, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, src1, src2, abort,
    output result, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle integer multiply/divide unit with a last-result cache.
// Multiply: magnitude product from four half-width partial products, sign applied at the end.
// Divide: restoring radix-2 on magnitudes, one quotient bit per edge, then a sign-fix edge.
// Cache holds {hi, lo} = {product high, product low} or {remainder, quotient}.
module alu_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_LAT  = 2,
  parameter int CACHE_EN = 1
) (
  input logic         CLK,
  input logic         RST,
  alu_muldiv_if.slave bus
);
  localparam int H    = WIDTH / 2;
  localparam int W2   = 2 * WIDTH;
  localparam int MAXC = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(MAXC + 1);

  // S_ONE: single-edge completion (cache hit or divide by zero); busy stays low.
  typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state_q, state_d;

  logic                        busy, accept, hit, dz, fin, is_div, sgn;
  logic [1:0]                  cls;
  logic [WIDTH-1:0]            abs1, abs2, fin_hi, fin_lo;
  logic [2:0]                  op_q;
  logic [WIDTH-1:0]            a_q, b_q, ma_q, mb_q, rem_q, quo_q;
  logic                        neg_q, rneg_q, one_dz_q;
  logic [CW-1:0]               cnt_q;
  logic [3:0][WIDTH-1:0]       pp_q, pp_d, pp_s;
  logic [W2-1:0]               sum_q, sum_d, mag, prod;
  logic [WIDTH:0]              div_sh, div_df;
  logic                        cv_q;
  logic [1:0]                  ccls_q;
  logic [WIDTH-1:0]            ca_q, cb_q, chi_q, clo_q;
  logic [WIDTH-1:0]            result_q;
  logic                        done_q, dzo_q;

  assign busy            = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.busy        = busy;
  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dzo_q;

  // Request decode: op class, operand magnitudes, cache lookup, accept.
  always_comb begin
    is_div = bus.op[2];
    sgn    = ~bus.op[1];
    cls    = bus.op[2:1];
    abs1   = (sgn && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    abs2   = (sgn && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
    hit    = (CACHE_EN != 0) && cv_q && (bus.src1 == ca_q) && (bus.src2 == cb_q) &&
             (cls == ccls_q);
    dz     = is_div && (bus.src2 == '0);
    accept = bus.start && !busy && !bus.abort;
  end

  // Multiplier: partial products, adder (registered when MUL_LAT >= 3), sign.
  always_comb begin
    pp_d[0] = WIDTH'(ma_q[H-1:0])     * WIDTH'(mb_q[H-1:0]);
    pp_d[1] = WIDTH'(ma_q[H-1:0])     * WIDTH'(mb_q[WIDTH-1:H]);
    pp_d[2] = WIDTH'(ma_q[WIDTH-1:H]) * WIDTH'(mb_q[H-1:0]);
    pp_d[3] = WIDTH'(ma_q[WIDTH-1:H]) * WIDTH'(mb_q[WIDTH-1:H]);
    pp_s    = (MUL_LAT == 1) ? pp_d : pp_q;
    sum_d   = W2'(pp_s[0]) + (W2'(pp_s[1]) << H) + (W2'(pp_s[2]) << H) +
              {pp_s[3], {WIDTH{1'b0}}};
    mag     = (MUL_LAT >= 3) ? sum_q : sum_d;
    prod    = neg_q ? -mag : mag;
    div_sh  = {rem_q, quo_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, mb_q};
  end

  // Completion values for whichever path finishes this edge.
  always_comb begin
    fin_hi = rem_q;
    fin_lo = quo_q;
    case (state_q)
      S_MUL: begin
        fin_hi = prod[W2-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
      end
      S_FIX: begin
        fin_hi = rneg_q ? -rem_q : rem_q;
        fin_lo = neg_q  ? -quo_q : quo_q;
      end
      default: ;
    endcase
  end

  // Next state; abort wins over completion.
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE, S_ONE: begin
        fin     = (state_q == S_ONE) && !bus.abort;
        state_d = S_IDLE;
        if (accept) state_d = (hit || dz) ? S_ONE : (is_div ? S_DIV : S_MUL);
      end
      S_MUL: begin
        if (bus.abort) state_d = S_IDLE;
        else if (cnt_q == CW'(MUL_LAT)) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (bus.abort) state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH)) state_d = S_FIX;
      end
      S_FIX: begin
        fin     = !bus.abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath, cache and outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= '0; a_q <= '0; b_q <= '0; ma_q <= '0; mb_q <= '0;
      rem_q <= '0; quo_q <= '0; neg_q <= 1'b0; rneg_q <= 1'b0; one_dz_q <= 1'b0;
      cnt_q <= '0; pp_q <= '0; sum_q <= '0;
      cv_q <= 1'b0; ccls_q <= '0; ca_q <= '0; cb_q <= '0; chi_q <= '0; clo_q <= '0;
      result_q <= '0; done_q <= 1'b0; dzo_q <= 1'b0;
    end else begin
      done_q <= fin;
      dzo_q  <= fin && (state_q == S_ONE) && one_dz_q;
      if (fin) begin
        result_q <= op_q[0] ? fin_hi : fin_lo;
        cv_q     <= (CACHE_EN != 0);
        ca_q     <= a_q;
        cb_q     <= b_q;
        ccls_q   <= op_q[2:1];
        chi_q    <= fin_hi;
        clo_q    <= fin_lo;
      end
      if (state_q == S_MUL) begin
        pp_q  <= pp_d;
        sum_q <= sum_d;
      end
      if (state_q == S_DIV) begin
        rem_q <= div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ~div_df[WIDTH]};
      end
      if (state_q == S_MUL || state_q == S_DIV) cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        op_q     <= bus.op;
        a_q      <= bus.src1;
        b_q      <= bus.src2;
        ma_q     <= abs1;
        mb_q     <= abs2;
        neg_q    <= sgn && (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
        rneg_q   <= sgn && bus.src1[WIDTH-1];
        one_dz_q <= dz;
        cnt_q    <= CW'(1);
        if (hit) begin
          rem_q <= chi_q;
          quo_q <= clo_q;
        end else if (dz) begin
          rem_q <= bus.src1;
          quo_q <= '1;
        end else begin
          rem_q <= '0;
          quo_q <= abs1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed scenarios plus randomized ops against an arithmetic model.
module tb_alu_muldiv;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;

  // Model of the last-result cache for the 32-bit unit.
  bit         cv = 1'b0;
  logic [31:0] ca, cb;
  logic [1:0]  ccls;

  always #5 CLK = ~CLK;

  alu_muldiv_if #(.WIDTH(32)) if0 ();
  alu_muldiv_if #(.WIDTH(16)) if1 ();

  alu_muldiv #(.WIDTH(32), .MUL_LAT(2), .CACHE_EN(1)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  alu_muldiv #(.WIDTH(16), .MUL_LAT(3), .CACHE_EN(0)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

  // Returns {div_by_zero, result} for a w-bit unit using plain integer arithmetic.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input int w);
    longint mask, ua, ub, sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] res;
    logic dz;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
    dz = 1'b0;
    if (!op[2]) begin
      p   = op[1] ? 64'(ua * ub) : 64'(sa * sb);
      res = 32'(op[0] ? ((p >> w) & 64'(mask)) : (p & 64'(mask)));
    end else begin
      if (ub == 0) begin
        dz = 1'b1; q = mask; r = ua;
      end else if (op[1]) begin
        q = ua / ub; r = ua % ub;
      end else begin
        q = sa / sb; r = sa % sb;
      end
      res = 32'((op[0] ? r : q) & mask);
    end
    return {dz, res};
  endfunction

  function automatic int exp_lat0(input logic [2:0] op, input logic [31:0] a, b);
    if (cv && a == ca && b == cb && op[2:1] == ccls) return 1;
    if (op[2] && b == 0) return 1;
    return op[2] ? 33 : 2;
  endfunction

  task automatic note0(input logic [2:0] op, input logic [31:0] a, b);
    cv = 1'b1; ca = a; cb = b; ccls = op[2:1];
  endtask

  // Issue one op on the 32-bit unit; lat = edges from accept to done (-1 on timeout).
  task automatic issue0(input logic [2:0] op, input logic [31:0] a, b, output int lat,
                        output logic [31:0] res, output bit dz, output bit bsy);
    bit seen = 1'b0;
    @(negedge CLK);
    if0.start = 1'b1; if0.op = op; if0.src1 = a; if0.src2 = b;
    @(posedge CLK); #1;
    if0.start = 1'b0;
    bsy = if0.busy; lat = 0; res = '0; dz = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (if0.done) begin
        seen = 1'b1; res = if0.result; dz = if0.div_by_zero;
      end else bsy |= if0.busy;
    end
    if (!seen) lat = -1;
  endtask

  task automatic issue1(input logic [2:0] op, input logic [15:0] a, b, output int lat,
                        output logic [15:0] res, output bit dz);
    bit seen = 1'b0;
    @(negedge CLK);
    if1.start = 1'b1; if1.op = op; if1.src1 = a; if1.src2 = b;
    @(posedge CLK); #1;
    if1.start = 1'b0;
    lat = 0; res = '0; dz = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (if1.done) begin
        seen = 1'b1; res = if1.result; dz = if1.div_by_zero;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (if0.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", if0.result); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if0.done); end
    checks++; if (if0.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", if0.div_by_zero); end
    checks++; if (if1.result !== 16'h0 || if1.busy !== 1'b0 || if1.done !== 1'b0)
      begin errors++; $display("FAIL reset_dut16 got r=%h b=%b d=%b want 0", if1.result, if1.busy, if1.done); end
    @(negedge CLK);
    RST = 1'b0;
    cv = 1'b0;
  endtask

  // Table-driven directed ops: result, latency, busy visibility, flag, pulse width.
  task automatic run_table(input string name, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[], input logic [31:0] er[], input int el[],
                           input bit ed[]);
    int lat; logic [31:0] res; bit dz, bsy;
    foreach (ops[i]) begin
      issue0(ops[i], as[i], bs[i], lat, res, dz, bsy);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL %s_res[%0d] got %h want %h", name, i, res, er[i]); end
      checks++; if (lat != el[i]) begin errors++; $display("FAIL %s_lat[%0d] got %0d want %0d", name, i, lat, el[i]); end
      checks++; if (bsy != (el[i] > 1)) begin errors++; $display("FAIL %s_busy[%0d] got %b want %b", name, i, bsy, el[i] > 1); end
      checks++; if (dz != ed[i]) begin errors++; $display("FAIL %s_dz[%0d] got %b want %b", name, i, dz, ed[i]); end
      note0(ops[i], as[i], bs[i]);
      @(posedge CLK); #1;
      checks++; if (if0.done !== 1'b0 || if0.div_by_zero !== 1'b0 || if0.result !== er[i])
        begin errors++; $display("FAIL %s_pulse[%0d] got d=%b z=%b r=%h want 0 0 %h", name, i, if0.done, if0.div_by_zero, if0.result, er[i]); end
    end
  endtask

  task automatic test_mul_cache();
    logic [2:0]  ops[] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000};
    logic [31:0] as[]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[]  = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] er[]  = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h1};
    int          el[]  = '{2, 1, 2, 1, 2};
    bit          ed[]  = '{0, 0, 0, 0, 0};
    run_table("mul", ops, as, bs, er, el, ed);
  endtask

  task automatic test_div();
    logic [2:0]  ops[] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b101};
    logic [31:0] as[]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] bs[]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] er[]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0};
    int          el[]  = '{33, 1, 1, 1, 33, 1};
    bit          ed[]  = '{0, 0, 1, 1, 0, 0};
    run_table("div", ops, as, bs, er, el, ed);
  endtask

  task automatic test_abort();
    int lat, ndone; logic [31:0] res, prev; bit dz, bsy;
    prev = if0.result;
    @(negedge CLK);
    if0.start = 1'b1; if0.op = 3'b100; if0.src1 = 32'd1000; if0.src2 = 32'd7;
    @(posedge CLK); #1;
    if0.start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    if0.abort = 1'b1;
    @(posedge CLK); #1;
    if0.abort = 1'b0;
    checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0)
      begin errors++; $display("FAIL abort_idle got b=%b d=%b want 0 0", if0.busy, if0.done); end
    ndone = 0;
    repeat (40) begin @(posedge CLK); #1; if (if0.done) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", ndone); end
    checks++; if (if0.result !== prev) begin errors++; $display("FAIL abort_hold got %h want %h", if0.result, prev); end
    issue0(3'b100, 32'd1000, 32'd7, lat, res, dz, bsy);
    checks++; if (lat != 33 || res !== 32'd142)
      begin errors++; $display("FAIL abort_reissue got lat=%0d r=%h want 33 %h", lat, res, 32'd142); end
    note0(3'b100, 32'd1000, 32'd7);
    // start together with abort while idle is dropped
    @(negedge CLK);
    if0.start = 1'b1; if0.abort = 1'b1; if0.op = 3'b000; if0.src1 = 32'd3; if0.src2 = 32'd4;
    @(posedge CLK); #1;
    if0.start = 1'b0; if0.abort = 1'b0;
    ndone = 0;
    repeat (4) begin @(posedge CLK); #1; if (if0.done || if0.busy) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_start_drop got %0d want 0", ndone); end
  endtask

  task automatic test_start_held();
    int ndone = 0, extra = 0;
    logic [31:0] res = '0;
    @(negedge CLK);
    if0.start = 1'b1; if0.op = 3'b110; if0.src1 = 32'd1000; if0.src2 = 32'd3;
    @(posedge CLK); #1;
    if0.op = 3'b000; if0.src1 = 32'd5; if0.src2 = 32'd9;
    for (int i = 0; i < 60 && ndone == 0; i++) begin
      @(posedge CLK); #1;
      if (if0.done) begin ndone++; res = if0.result; if0.start = 1'b0; end
    end
    if0.start = 1'b0;
    repeat (5) begin @(posedge CLK); #1; if (if0.done || if0.busy) extra++; end
    checks++; if (ndone != 1 || res !== 32'd333)
      begin errors++; $display("FAIL held_first got n=%0d r=%h want 1 %h", ndone, res, 32'd333); end
    checks++; if (extra != 0) begin errors++; $display("FAIL held_second got %0d want 0", extra); end
    note0(3'b110, 32'd1000, 32'd3);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge CLK);
    if0.start = 1'b1; if0.op = 3'b000; if0.src1 = 32'd5; if0.src2 = 32'd6;
    @(posedge CLK); #1;
    if0.start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (if0.result !== 32'h0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.div_by_zero !== 1'b0)
      begin errors++; $display("FAIL rstmid_out got r=%h b=%b d=%b z=%b want 0", if0.result, if0.busy, if0.done, if0.div_by_zero); end
    @(negedge CLK);
    RST = 1'b0;
    cv = 1'b0;
    repeat (5) begin @(posedge CLK); #1; if (if0.done) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL rstmid_nodone got %0d want 0", n); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a = 0, b = 0, res; logic [32:0] exp;
    int lat, elat; bit dz, bsy;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      if (n == 0 || $urandom_range(0, 2) != 0) begin
        a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 9))
          0: b = 32'h0;
          1: b = 32'($urandom_range(1, 5));
          2: b = 32'hFFFFFFFF;
          default: b = $urandom;
        endcase
      end
      exp  = model(op, a, b, 32);
      elat = exp_lat0(op, a, b);
      issue0(op, a, b, lat, res, dz, bsy);
      checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL rnd_res[%0d] op=%b a=%h b=%h got %h want %h", n, op, a, b, res, exp[31:0]); end
      checks++; if (dz != exp[32]) begin errors++; $display("FAIL rnd_dz[%0d] got %b want %b", n, dz, exp[32]); end
      checks++; if (lat != elat || bsy != (elat > 1))
        begin errors++; $display("FAIL rnd_lat[%0d] got %0d/%b want %0d/%b", n, lat, bsy, elat, elat > 1); end
      note0(op, a, b);
      @(posedge CLK); #1;
      checks++; if (if0.done !== 1'b0 || if0.result !== exp[31:0])
        begin errors++; $display("FAIL rnd_hold[%0d] got d=%b r=%h want 0 %h", n, if0.done, if0.result, exp[31:0]); end
    end
  endtask

  task automatic test_nocache();
    logic [2:0] op; logic [15:0] a, b, res; logic [32:0] exp;
    int lat, elat; bit dz;
    for (int r = 0; r < 2; r++) begin
      issue1(3'b001, 16'h8000, 16'h8000, lat, res, dz);
      checks++; if (res !== 16'h4000 || lat != 3)
        begin errors++; $display("FAIL nc_mulh[%0d] got r=%h lat=%0d want 4000 3", r, res, lat); end
    end
    for (int n = 0; n < 12; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      exp  = model(op, {16'h0, a}, {16'h0, b}, 16);
      elat = !op[2] ? 3 : (b == 0 ? 1 : 17);
      issue1(op, a, b, lat, res, dz);
      checks++; if (res !== exp[15:0] || dz != exp[32] || lat != elat)
        begin errors++; $display("FAIL nc_rnd[%0d] op=%b a=%h b=%h got %h/%b/%0d want %h/%b/%0d", n, op, a, b, res, dz, lat, exp[15:0], exp[32], elat); end
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.op = '0; if0.src1 = '0; if0.src2 = '0; if0.abort = 1'b0;
    if1.start = 1'b0; if1.op = '0; if1.src1 = '0; if1.src2 = '0; if1.abort = 1'b0;
    test_reset();
    test_mul_cache();
    test_div();
    test_abort();
    test_start_held();
    test_reset_mid();
    test_random();
    test_nocache();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle integer multiply/divide unit for the CPU execute stage; successor to the fixed 32-bit multiplier.
- WIDTH-generic, with a configurable multiply pipeline depth and an iterative radix-2 divider.
- Caches both halves of the last completed result (hi/lo or quotient/remainder), so a back-to-back companion op finishes in one cycle.
- Supports abort for pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; any even value ≥8.
- MUL_LAT, 2, multiply latency in clock edges from accept to done; must be ≥1.
- CACHE_EN, 1, enables the last-result cache (0 = every op takes full latency).

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled only when busy=0.
- op  in  3  000 MULL, 001 MULH, 010 MULLU, 011 MULHU, 100 DIVQ, 101 DIVR, 110 DIVQU, 111 DIVRU.
- src1  in  WIDTH  multiplicand / dividend.
- src2  in  WIDTH  multiplier / divisor.
- abort  in  1  cancels the in-flight op.
- result  out  WIDTH  result; valid from done until the next done.
- busy  out  1  op in flight.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  pulses with done for a divide with src2=0.

Behaviour:
- Reset (RST=1 at posedge):
  - result=0, busy=0, done=0, div_by_zero=0.
  - Cache invalid; divider/multiplier state cleared.
  - Reset mid-operation discards the op silently; no done is produced.
- Accept: edge k with start=1, busy=0, RST=0, abort=0.
  - op, src1, src2 are latched.
  - start while busy=1 is ignored; no queueing.
- Operation class: {mul signed, mul unsigned, div signed, div unsigned}.
- Cache hit: CACHE_EN=1, cache valid, and src1, src2 and class equal the last completed op.
  - After edge k+1: done=1, result = the selected half.
  - busy never rises.
- Multiply, miss:
  - busy=1 after edge k.
  - After edge k+MUL_LAT: busy=0, done=1.
  - The 2·WIDTH product goes into the cache; result = low half (MULL/MULLU) or high half (MULH/MULHU).
  - Signed mode treats both operands as two's complement.
  - Implementation: half-width partial products registered in stage 1, summed in the final stage; extra stages pipeline the adder tree.
- Divide, miss, src2≠0:
  - Restoring radix-2 on operand magnitudes, one quotient bit per edge.
  - busy=1 for edges k..k+WIDTH; after edge k+WIDTH+1: busy=0, done=1 (the last edge applies the sign fix).
  - Signed rules: quotient truncates toward zero; remainder takes the dividend's sign.
  - src1 = signed MIN with src2 = -1: quotient = MIN, remainder = 0, no flag.
  - Quotient and remainder both go into the cache.
- Divide by zero (src2=0):
  - Done after edge k+1; busy never rises.
  - Quotient = all ones; remainder = src1.
  - div_by_zero=1 for the done cycle only.
  - The cache is updated normally.
- done and div_by_zero are single-cycle pulses; result holds between dones.
- abort=1 at any edge while busy:
  - busy=0 after that edge, no done, result unchanged, cache not updated.
  - abort with start at the same edge while idle: the start is dropped.
  - abort takes priority over completion at the same edge.
- A new op may be accepted on the same edge at which done rises (busy=0 at that edge).

Test Plan:
1. MULL, src1=0xFFFFFFFD, src2=7 -> done 2 edges after accept, result=0xFFFFFFEB. Then MULH with the same operands -> done after 1 edge, busy stays 0, result=0xFFFFFFFF.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. Then MULLU with the same operands -> cache hit, result=0x00000001. Then MULL with the same operands -> miss (class differs), full latency, result=0x00000001.
3. DIVQ, src1=0xFFFFFFF9 (-7), src2=2 -> done 33 edges after accept, result=0xFFFFFFFD. Then DIVR -> hit, result=0xFFFFFFFF.
4. DIVQU 100/0 -> done after 1 edge, result=0xFFFFFFFF, div_by_zero=1. Then DIVRU 100/0 -> result=100. Then DIVQ 0x80000000/0xFFFFFFFF -> result=0x80000000, and DIVR -> 0.
5. Start DIVQ, assert abort on the 5th busy cycle -> busy=0 next edge, no done. Reissue the same op -> full 33-edge latency. Repeat with RST mid-MULL -> all outputs 0, no done. start held during busy -> no second op.
6. WIDTH=16, MUL_LAT=3, CACHE_EN=0: MULH 0x8000×0x8000 -> 0x4000 after 3 edges. An immediate repeat -> 3 edges again (no cache).
